// File: rtl/sign_restore_deframer.sv
// -----------------------------------------------------------------------------
// sign_restore_deframer
//
// Receive-side inverse of the absolute-value / sign-split path for EEG sample
// frames. A frame is one sign word (one bit per channel, bit i = 1 means
// channel i is negative) followed by NCH unsigned magnitudes in channel order.
// Each magnitude is turned back into a signed two's-complement sample and sent
// downstream together with its channel index and a last-of-frame flag.
//
// Handshake (all three streams): a transfer happens on a rising clock edge
// where valid && ready are both high. A producer holds valid and its payload
// stable until the transfer. Ready never depends on the same stream's valid,
// so there are no combinational valid->ready loops.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   sign_valid   sign word available
//   sign_word    [NCH-1:0] per-channel sign bits of the next frame
//   sign_ready   block accepts a sign word this cycle (only in IDLE)
//   mag_valid    magnitude available
//   mag_in       [bitnum-2:0] unsigned magnitude
//   mag_ready    block accepts a magnitude this cycle (only in EMIT)
//   out_valid    out_data/out_ch/out_last valid
//   out_ready    downstream accepts the output
//   out_data     [bitnum-1:0] signed sample
//   out_ch       [CHW-1:0] channel index of out_data
//   out_last     out_data belongs to channel NCH-1
//   negzero_err  one-cycle pulse: a negative sign with magnitude 0 was accepted
//   dbg_state    current FSM state (0 = IDLE, 1 = EMIT)
// -----------------------------------------------------------------------------
module sign_restore_deframer #(
  parameter int bitnum = 13,
  parameter int NCH    = 8,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sign_valid,
  input  logic [NCH-1:0]    sign_word,
  output logic              sign_ready,
  input  logic              mag_valid,
  input  logic [bitnum-2:0] mag_in,
  output logic              mag_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [bitnum-1:0] out_data,
  output logic [CHW-1:0]    out_ch,
  output logic              out_last,
  output logic              negzero_err,
  output logic              dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [NCH-1:0]      r_sign;
  logic [CHW-1:0]      r_ch;
  logic [bitnum-1:0]   r_out_data;
  logic [CHW-1:0]      r_out_ch;
  logic                r_out_last;
  logic                r_out_valid;
  logic                r_negzero;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t              w_state_nxt;
  logic                w_sign_ready;
  logic                w_mag_ready;
  logic                w_sign_xfer;
  logic                w_mag_xfer;
  logic                w_neg;
  logic                w_ch_last;
  logic                w_mag_zero;
  logic [bitnum-1:0]   w_mag_ext;
  logic [bitnum-1:0]   w_result;

  assign w_sign_xfer = sign_valid && w_sign_ready;
  assign w_mag_xfer  = mag_valid  && w_mag_ready;

  // Sign bit of the channel whose magnitude is currently offered.
  assign w_neg       = r_sign[r_ch];
  assign w_ch_last   = (r_ch == CH_LAST);
  assign w_mag_zero  = (mag_in == '0);

  // The magnitude is one bit narrower than the sample, so the zero-extended
  // value is at most 2^(bitnum-1)-1 and its negation never reaches the
  // most-negative code. Negating zero yields zero, so a "negative zero" input
  // comes out as a clean 0 rather than an all-ones artefact.
  assign w_mag_ext   = {1'b0, mag_in};
  assign w_result    = w_neg ? (bitnum'(0) - w_mag_ext) : w_mag_ext;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake readies
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_sign_ready = 1'b0;
    w_mag_ready  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_sign_ready = 1'b1;
        if (sign_valid) begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        // Single-entry output register: a new magnitude may enter when the
        // register is empty or is being drained in this same cycle, so
        // downstream backpressure reaches mag_ready without a cycle of delay.
        w_mag_ready = !r_out_valid || out_ready;
        if (mag_valid && w_mag_ready && w_ch_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame context: latched sign word and channel counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign <= '0;
      r_ch   <= '0;
    end else begin
      if (w_sign_xfer) begin
        r_sign <= sign_word;
        r_ch   <= '0;
      end else if (w_mag_xfer) begin
        // Wrap explicitly at the end of a frame; the next sign transfer also
        // clears the counter, so either path leaves ch at 0 for a new frame.
        r_ch <= w_ch_last ? '0 : (r_ch + CHW'(1));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_mag_xfer) begin
        // Reload, even if the previous word is leaving this same cycle.
        r_out_data  <= w_result;
        r_out_ch    <= r_ch;
        r_out_last  <= w_ch_last;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Negative-zero indicator: pulses for exactly the cycle after the accept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_negzero <= 1'b0;
    end else begin
      r_negzero <= w_mag_xfer && w_neg && w_mag_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sign_ready  = w_sign_ready;
  assign mag_ready   = w_mag_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_ch      = r_out_ch;
  assign out_last    = r_out_last;
  assign negzero_err = r_negzero;
  assign dbg_state   = r_state;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // The most-negative code cannot be produced from a bitnum-1 bit magnitude.
  a_no_most_negative: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> (out_data != {1'b1, {(bitnum-1){1'b0}}}));

  // A stalled output word stays put until it is taken.
  a_hold_when_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) &&
                                   $stable(out_ch) && $stable(out_last)));

  // Only one of the two input streams can be ready in any cycle.
  a_ready_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(sign_ready && mag_ready));

endmodule
